// File: rtl/move_recorder.sv
// Move recorder: logs the maze solver's 2-bit moves into a packed 44-bit order word
// with backtracking, optional cancellation of opposite moves, and overflow detection.
module move_recorder #(
  parameter int unsigned MAX_MOVES = 22,
  parameter bit          COMPRESS  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        push_vld_i,
  input  logic [1:0]  push_dir_i,
  input  logic        pop_i,
  input  logic        done_i,
  output logic [43:0] ord_o,
  output logic [43:0] cnt_o,
  output logic        comp_o,
  output logic        busy_o,
  output logic        overflow_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REC = 2'd1, COMP = 2'd2, ERR = 2'd3} state_t;

  localparam logic [4:0] MAX_CNT = 5'(MAX_MOVES);

  state_t      state_q, state_d;
  logic [43:0] ord_q, ord_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        comp_q, busy_q;
  logic        full_push_s;
  logic [4:0]  top_idx_s;
  logic [1:0]  top_s;

  function automatic logic [43:0] put_slot(input logic [43:0] ord, input logic [4:0] idx,
                                           input logic [1:0] dir);
    logic [5:0] sh;
    sh = {idx, 1'b0};
    return (ord & ~(44'h3 << sh)) | ({42'd0, dir} << sh);
  endfunction

  function automatic logic [1:0] get_slot(input logic [43:0] ord, input logic [4:0] idx);
    return 2'(ord >> {idx, 1'b0});
  endfunction

  // Next-state and log update for the current cycle's request
  always_comb begin
    state_d     = state_q;
    ord_d       = ord_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    full_push_s = 1'b0;
    top_idx_s   = cnt_q - 5'd1;
    top_s       = get_slot(ord_q, top_idx_s);
    case (state_q)
      REC: begin
        if (start_i) begin
          ord_d   = 44'd0;
          cnt_d   = 5'd0;
          ovf_d   = 1'b0;
          state_d = REC;
        end else begin
          if (push_vld_i && pop_i && (cnt_q != 5'd0)) begin
            ord_d = put_slot(ord_q, top_idx_s, push_dir_i);
          end else if (pop_i && !push_vld_i) begin
            if (cnt_q != 5'd0) begin
              ord_d = put_slot(ord_q, top_idx_s, 2'b00);
              cnt_d = top_idx_s;
            end else begin
              cnt_d = cnt_q;
            end
          end else if (push_vld_i) begin
            // An opposite push undoes the last step instead of growing the log
            if (COMPRESS && (cnt_q != 5'd0) && ((push_dir_i ^ top_s) == 2'b11)) begin
              ord_d = put_slot(ord_q, top_idx_s, 2'b00);
              cnt_d = top_idx_s;
            end else if (cnt_q < MAX_CNT) begin
              ord_d = put_slot(ord_q, cnt_q, push_dir_i);
              cnt_d = cnt_q + 5'd1;
            end else begin
              ovf_d       = 1'b1;
              full_push_s = 1'b1;
            end
          end else begin
            cnt_d = cnt_q;
          end
          if (full_push_s) begin
            state_d = ERR;
          end else if (done_i) begin
            state_d = COMP;
          end else begin
            state_d = REC;
          end
        end
      end
      IDLE, COMP, ERR: begin
        if (start_i) begin
          ord_d   = 44'd0;
          cnt_d   = 5'd0;
          ovf_d   = 1'b0;
          state_d = REC;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, log and status flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ord_q   <= 44'd0;
      cnt_q   <= 5'd0;
      ovf_q   <= 1'b0;
      comp_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ord_q   <= ord_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      comp_q  <= (state_d == COMP);
      busy_q  <= (state_d == REC);
    end
  end

  assign ord_o      = ord_q;
  assign cnt_o      = {39'd0, cnt_q};
  assign comp_o     = comp_q;
  assign busy_o     = busy_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_move_recorder.sv
// Self-checking bench for move_recorder: directed scenarios plus random traffic
// compared against a queue-based model of the move log.
module tb_move_recorder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0, push_vld_i = 1'b0, pop_i = 1'b0, done_i = 1'b0;
  logic [1:0]  push_dir_i = 2'b00;
  logic [43:0] ord_o, cnt_o;
  logic        comp_o, busy_o, overflow_o;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] UP = 2'b01, DOWN = 2'b10, LEFT = 2'b11, RIGHT = 2'b00;

  // model: 0 idle, 1 recording, 2 complete, 3 error
  logic [1:0] mq[$];
  int         m_mode = 0;
  bit         m_ovf = 1'b0;

  move_recorder #(.MAX_MOVES(22), .COMPRESS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .push_vld_i(push_vld_i),
    .push_dir_i(push_dir_i), .pop_i(pop_i), .done_i(done_i), .ord_o(ord_o),
    .cnt_o(cnt_o), .comp_o(comp_o), .busy_o(busy_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  function automatic logic [43:0] exp_ord();
    logic [43:0] r;
    r = 44'd0;
    for (int i = 0; i < mq.size(); i++) r = r | (44'(mq[i]) << (2 * i));
    return r;
  endfunction

  task automatic model_step(input bit rn, input bit st, input bit pv, input logic [1:0] d,
                            input bit pp, input bit dn);
    bit ovf_push;
    if (!rn) begin
      mq.delete(); m_mode = 0; m_ovf = 1'b0;
    end else if (st) begin
      mq.delete(); m_mode = 1; m_ovf = 1'b0;
    end else if (m_mode == 1) begin
      ovf_push = 1'b0;
      if (pv && pp && mq.size() > 0) mq[mq.size()-1] = d;
      else if (pp && !pv) begin
        if (mq.size() > 0) void'(mq.pop_back());
      end else if (pv) begin
        if (mq.size() > 0 && (d ^ mq[mq.size()-1]) == 2'b11) void'(mq.pop_back());
        else if (mq.size() < 22) mq.push_back(d);
        else begin m_ovf = 1'b1; m_mode = 3; ovf_push = 1'b1; end
      end
      if (dn && !ovf_push) m_mode = 2;
    end
  endtask

  task automatic cycle(input bit rn, input bit st, input bit pv, input logic [1:0] d,
                       input bit pp, input bit dn);
    rst_n = rn; start_i = st; push_vld_i = pv; push_dir_i = d; pop_i = pp; done_i = dn;
    @(posedge clk);
    model_step(rn, st, pv, d, pp, dn);
    #1;
    start_i = 1'b0; push_vld_i = 1'b0; pop_i = 1'b0; done_i = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 1'b0, RIGHT, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, RIGHT, 1'b0, 1'b0);
    checks++;
    if (ord_o !== 44'd0 || cnt_o !== 44'd0 || comp_o !== 1'b0 || busy_o !== 1'b0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: ord=%h cnt=%0d comp=%b busy=%b ovf=%b, expected all zero", ord_o, cnt_o, comp_o, busy_o, overflow_o);
    end
  endtask

  task automatic test_basic();
    cycle(1'b1, 1'b1, 1'b0, RIGHT, 1'b0, 1'b0);
    checks++;
    if (busy_o !== 1'b1 || cnt_o !== 44'd0) begin
      errors++; $display("FAIL start_busy: busy=%b cnt=%0d, expected busy=1 cnt=0", busy_o, cnt_o);
    end
    cycle(1'b1, 1'b0, 1'b1, UP, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, LEFT, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, DOWN, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, RIGHT, 1'b0, 1'b1);
    checks++;
    if (comp_o !== 1'b1 || cnt_o !== 44'd3 || ord_o !== 44'h0000000002D || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: comp=%b cnt=%0d ord=%h busy=%b, expected comp=1 cnt=3 ord=0000000002d busy=0", comp_o, cnt_o, ord_o, busy_o);
    end
    cycle(1'b1, 1'b0, 1'b1, UP, 1'b1, 1'b1);
    checks++;
    if (comp_o !== 1'b1 || cnt_o !== 44'd3 || ord_o !== 44'h0000000002D) begin
      errors++; $display("FAIL comp_frozen: comp=%b cnt=%0d ord=%h, expected 1/3/0000000002d", comp_o, cnt_o, ord_o);
    end
  endtask

  task automatic test_compress();
    cycle(1'b1, 1'b1, 1'b0, RIGHT, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, UP, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, DOWN, 1'b0, 1'b0);
    checks++;
    if (cnt_o !== 44'd0 || ord_o !== 44'd0) begin
      errors++; $display("FAIL compress_cancel: cnt=%0d ord=%h, expected 0/0", cnt_o, ord_o);
    end
    cycle(1'b1, 1'b0, 1'b1, RIGHT, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, RIGHT, 1'b0, 1'b1);
    checks++;
    if (cnt_o !== 44'd1 || ord_o !== 44'd0 || comp_o !== 1'b1) begin
      errors++; $display("FAIL compress_right: cnt=%0d ord=%h comp=%b, expected 1/0/1", cnt_o, ord_o, comp_o);
    end
  endtask

  task automatic test_backtrack();
    int exp_cnt[5] = '{1, 2, 1, 0, 0};
    cycle(1'b1, 1'b1, 1'b0, RIGHT, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) cycle(1'b1, 1'b0, 1'b1, LEFT, 1'b0, 1'b0);
      else if (i == 1) cycle(1'b1, 1'b0, 1'b1, UP, 1'b0, 1'b0);
      else cycle(1'b1, 1'b0, 1'b0, RIGHT, 1'b1, 1'b0);
      checks++;
      if (cnt_o !== 44'(exp_cnt[i]) || overflow_o !== 1'b0) begin
        errors++; $display("FAIL backtrack_%0d: cnt=%0d ovf=%b, expected cnt=%0d ovf=0", i, cnt_o, overflow_o, exp_cnt[i]);
      end
    end
    checks++;
    if (ord_o !== 44'd0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL backtrack_end: ord=%h busy=%b, expected 0/1", ord_o, busy_o);
    end
  endtask

  task automatic test_capacity();
    cycle(1'b1, 1'b1, 1'b0, RIGHT, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) cycle(1'b1, 1'b0, 1'b1, LEFT, 1'b0, 1'b0);
    checks++;
    if (ord_o !== 44'hFFFFFFFFFFF || cnt_o !== 44'd22 || overflow_o !== 1'b0) begin
      errors++; $display("FAIL capacity_full: ord=%h cnt=%0d ovf=%b, expected fffffffffff/22/0", ord_o, cnt_o, overflow_o);
    end
    cycle(1'b1, 1'b0, 1'b1, LEFT, 1'b0, 1'b0);
    checks++;
    if (overflow_o !== 1'b1 || busy_o !== 1'b0 || ord_o !== 44'hFFFFFFFFFFF || cnt_o !== 44'd22) begin
      errors++; $display("FAIL overflow: ovf=%b busy=%b ord=%h cnt=%0d, expected 1/0/fffffffffff/22", overflow_o, busy_o, ord_o, cnt_o);
    end
    cycle(1'b1, 1'b0, 1'b0, RIGHT, 1'b1, 1'b1);
    checks++;
    if (comp_o !== 1'b0 || overflow_o !== 1'b1 || cnt_o !== 44'd22) begin
      errors++; $display("FAIL err_done: comp=%b ovf=%b cnt=%0d, expected 0/1/22", comp_o, overflow_o, cnt_o);
    end
    cycle(1'b1, 1'b1, 1'b0, RIGHT, 1'b0, 1'b0);
    checks++;
    if (overflow_o !== 1'b0 || busy_o !== 1'b1 || cnt_o !== 44'd0 || ord_o !== 44'd0) begin
      errors++; $display("FAIL err_restart: ovf=%b busy=%b cnt=%0d ord=%h, expected 0/1/0/0", overflow_o, busy_o, cnt_o, ord_o);
    end
  endtask

  task automatic test_push_pop();
    cycle(1'b1, 1'b1, 1'b0, RIGHT, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, LEFT, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, UP, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, RIGHT, 1'b1, 1'b1);
    checks++;
    if (cnt_o !== 44'd2 || ord_o !== 44'h00000000003 || comp_o !== 1'b1) begin
      errors++; $display("FAIL push_pop_done: cnt=%0d ord=%h comp=%b, expected 2/00000000003/1", cnt_o, ord_o, comp_o);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b1, 1'b0, RIGHT, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, UP, 1'b0, 1'b0);
    checks++;
    if (cnt_o !== 44'd5 || ord_o !== 44'h00000000155) begin
      errors++; $display("FAIL pre_reset: cnt=%0d ord=%h, expected 5/00000000155", cnt_o, ord_o);
    end
    cycle(1'b0, 1'b0, 1'b1, UP, 1'b0, 1'b0);
    checks++;
    if (ord_o !== 44'd0 || cnt_o !== 44'd0 || busy_o !== 1'b0 || comp_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid: ord=%h cnt=%0d busy=%b comp=%b, expected 0/0/0/0", ord_o, cnt_o, busy_o, comp_o);
    end
    cycle(1'b1, 1'b0, 1'b1, UP, 1'b0, 1'b1);
    checks++;
    if (busy_o !== 1'b0 || cnt_o !== 44'd0 || comp_o !== 1'b0) begin
      errors++; $display("FAIL idle_ignore: busy=%b cnt=%0d comp=%b, expected 0/0/0", busy_o, cnt_o, comp_o);
    end
    cycle(1'b1, 1'b1, 1'b0, RIGHT, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, DOWN, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, RIGHT, 1'b0, 1'b0);
    checks++;
    if (comp_o !== 1'b0 || cnt_o !== 44'd0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL comp_restart: comp=%b cnt=%0d busy=%b, expected 0/0/1", comp_o, cnt_o, busy_o);
    end
  endtask

  task automatic test_random();
    bit rn, st, pv, pp, dn;
    logic [1:0] d;
    for (int n = 0; n < 3000; n++) begin
      rn = ($urandom_range(0, 199) != 0);
      st = ($urandom_range(0, 39) == 0);
      pv = ($urandom_range(0, 9) < 6);
      pp = ($urandom_range(0, 9) < 2);
      dn = ($urandom_range(0, 29) == 0);
      d  = ($urandom_range(0, 1) == 0) ? LEFT : 2'($urandom_range(0, 3));
      if (m_mode != 1 && $urandom_range(0, 3) == 0) st = 1'b1;
      cycle(rn, st, pv, d, pp, dn);
      checks++;
      if (ord_o !== exp_ord() || cnt_o !== 44'(mq.size()) || comp_o !== (m_mode == 2) ||
          busy_o !== (m_mode == 1) || overflow_o !== m_ovf) begin
        errors++;
        $display("FAIL random_%0d: ord=%h cnt=%0d comp=%b busy=%b ovf=%b, expected ord=%h cnt=%0d comp=%b busy=%b ovf=%b",
                 n, ord_o, cnt_o, comp_o, busy_o, overflow_o, exp_ord(), mq.size(),
                 m_mode == 2, m_mode == 1, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_compress();
    test_backtrack();
    test_capacity();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
